// File: rtl/switch_pkg.sv
// Shared types for the 1-to-2 stream switch: destination decode and slot states.
package switch_pkg;

  typedef enum logic [1:0] {
    DEST_A    = 2'd0,
    DEST_B    = 2'd1,
    DEST_DROP = 2'd2
  } dest_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Mismatched select bits mark a beat to be discarded.
  function automatic dest_t decode_dest(input logic sel_b, input logic sel_a);
    dest_t d;
    case ({sel_b, sel_a})
      2'b00:   d = DEST_A;
      2'b11:   d = DEST_B;
      default: d = DEST_DROP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/switch_1to2_out_slot.sv
// One-entry output holding slot for a single channel of switch_1to2.
//   state      | meaning
//   SLOT_EMPTY | no beat held, o_valid=0
//   SLOT_FULL  | beat held on o_data, o_valid=1 until consumed
module out_slot
  import switch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_can_accept
);

  slot_state_t       r_state;
  slot_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load in the same cycle as a consume keeps the slot full with new data.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (i_ready && !i_load) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
    end
  end

  assign o_valid      = (r_state == SLOT_FULL);
  assign o_data       = r_data;
  assign o_can_accept = !o_valid || i_ready;

endmodule

// File: rtl/switch_1to2.sv
// 1-to-2 stream switch with per-channel holding slots and a drop destination.
// Optional saturating drop counter on port drop_cnt when SWITCH_DROP_CNT_EN is defined.
module switch_1to2
  import switch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_a,
  input  logic              sel_b,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_a_valid,
  output logic [DATA_W-1:0] out_a_data,
  input  logic              out_a_ready,
  output logic              out_b_valid,
  output logic [DATA_W-1:0] out_b_data,
  input  logic              out_b_ready
`ifdef SWITCH_DROP_CNT_EN
  ,
  output logic [CNT_W-1:0]  drop_cnt
`endif
);

  dest_t w_dest;
  logic  w_in_ready;
  logic  w_xfer;
  logic  w_load_a;
  logic  w_load_b;
  logic  w_a_can_accept;
  logic  w_b_can_accept;

  assign w_dest = decode_dest(sel_b, sel_a);

  // Ready looks only at the selected slot, never at in_valid.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      case (w_dest)
        DEST_A:  w_in_ready = w_a_can_accept;
        DEST_B:  w_in_ready = w_b_can_accept;
        default: w_in_ready = 1'b1;
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign w_xfer   = in_valid && w_in_ready;
  assign w_load_a = w_xfer && (w_dest == DEST_A);
  assign w_load_b = w_xfer && (w_dest == DEST_B);

  out_slot #(.DATA_W(DATA_W)) u_slot_a (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load_a),
    .i_load_data  (in_data),
    .i_ready      (out_a_ready),
    .o_valid      (out_a_valid),
    .o_data       (out_a_data),
    .o_can_accept (w_a_can_accept)
  );

  out_slot #(.DATA_W(DATA_W)) u_slot_b (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load_b),
    .i_load_data  (in_data),
    .i_ready      (out_b_ready),
    .o_valid      (out_b_valid),
    .o_data       (out_b_data),
    .o_can_accept (w_b_can_accept)
  );

`ifdef SWITCH_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_drop_xfer;

  assign w_drop_xfer = w_xfer && (w_dest == DEST_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop_xfer && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  // Width stays on the parameter list so both builds share one interface.
  localparam int LP_UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_switch_1to2.sv
// Directed self-checking bench for switch_1to2 (default and SWITCH_DROP_CNT_EN builds).
module tb_switch_1to2;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              sel_a;
  logic              sel_b;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_a_valid;
  logic [DATA_W-1:0] out_a_data;
  logic              out_a_ready;
  logic              out_b_valid;
  logic [DATA_W-1:0] out_b_data;
  logic              out_b_ready;
`ifdef SWITCH_DROP_CNT_EN
  logic [CNT_W-1:0]  drop_cnt;
`endif

  int n_cmp;
  int n_err;

  switch_1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_a_valid (out_a_valid),
    .out_a_data  (out_a_data),
    .out_a_ready (out_a_ready),
    .out_b_valid (out_b_valid),
    .out_b_data  (out_b_data),
    .out_b_ready (out_b_ready)
`ifdef SWITCH_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_a = 1'b0; sel_b = 1'b0; in_valid = 1'b1; in_data = 8'hEE;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_err++; $display("FAIL reset_valids got %b%b want 00", out_a_valid, out_b_valid); end
    n_cmp++; if (out_a_data !== 8'h00 || out_b_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h/%h want 00/00", out_a_data, out_b_data); end
`ifdef SWITCH_DROP_CNT_EN
    n_cmp++; if (drop_cnt !== 4'd0) begin n_err++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_a();
    sel_a = 1'b0; sel_b = 1'b0; in_data = 8'h5A; in_valid = 1'b1; out_a_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_a_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_a_valid !== 1'b1 || out_a_data !== 8'h5A) begin n_err++; $display("FAIL single_a_out got v=%b d=%h want v=1 d=5a", out_a_valid, out_a_data); end
    n_cmp++; if (out_b_valid !== 1'b0) begin n_err++; $display("FAIL single_a_b_quiet got %b want 0", out_b_valid); end
    tick();
    n_cmp++; if (out_a_valid !== 1'b0) begin n_err++; $display("FAIL single_a_drain got %b want 0", out_a_valid); end
  endtask

  task automatic test_back_to_back();
    sel_a = 1'b1; sel_b = 1'b1; out_b_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready beat %0d got %b want 1", i, in_ready); end
      tick();
      n_cmp++; if (out_b_valid !== 1'b1 || out_b_data !== 8'(i)) begin n_err++; $display("FAIL b2b_out beat %0d got v=%b d=%h want v=1 d=%h", i, out_b_valid, out_b_data, 8'(i)); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_b_valid !== 1'b0 || out_a_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got a=%b b=%b want 0 0", out_a_valid, out_b_valid); end
  endtask

  task automatic test_stall_and_isolation();
    sel_a = 1'b0; sel_b = 1'b0; out_a_ready = 1'b0; in_data = 8'h11; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_first_ready got %b want 1", in_ready); end
    tick();
    in_data = 8'h22;
    #1;
    n_cmp++; if (out_a_valid !== 1'b1 || out_a_data !== 8'h11) begin n_err++; $display("FAIL stall_hold got v=%b d=%h want v=1 d=11", out_a_valid, out_a_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_second_ready got %b want 0", in_ready); end
    tick();
    n_cmp++; if (out_a_valid !== 1'b1 || out_a_data !== 8'h11) begin n_err++; $display("FAIL stall_hold2 got v=%b d=%h want v=1 d=11", out_a_valid, out_a_data); end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ready_no_valid got %b want 0", in_ready); end
    // B traffic while A is stalled.
    sel_a = 1'b1; sel_b = 1'b1; out_b_ready = 1'b1; in_data = 8'h33; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL iso_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_b_valid !== 1'b1 || out_b_data !== 8'h33) begin n_err++; $display("FAIL iso_b_out got v=%b d=%h want v=1 d=33", out_b_valid, out_b_data); end
    n_cmp++; if (out_a_valid !== 1'b1 || out_a_data !== 8'h11) begin n_err++; $display("FAIL iso_a_hold got v=%b d=%h want v=1 d=11", out_a_valid, out_a_data); end
    tick();
    n_cmp++; if (out_b_valid !== 1'b0) begin n_err++; $display("FAIL iso_b_drain got %b want 0", out_b_valid); end
    // Release A: 0x11 leaves this cycle while 0x22 is accepted.
    sel_a = 1'b0; sel_b = 1'b0; in_data = 8'h22; in_valid = 1'b1; out_a_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_a_data !== 8'h11) begin n_err++; $display("FAIL release_first got rdy=%b d=%h want rdy=1 d=11", in_ready, out_a_data); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_a_valid !== 1'b1 || out_a_data !== 8'h22) begin n_err++; $display("FAIL release_second got v=%b d=%h want v=1 d=22", out_a_valid, out_a_data); end
    tick();
    n_cmp++; if (out_a_valid !== 1'b0) begin n_err++; $display("FAIL release_drain got %b want 0", out_a_valid); end
  endtask

  task automatic test_drop();
    logic [1:0] sels [2];
    sels[0] = 2'b01;
    sels[1] = 2'b10;
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {sel_b, sel_a} = sels[i]; in_data = 8'hD0 + 8'(i); in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready sel=%b got %b want 1", sels[i], in_ready); end
      tick();
      n_cmp++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_err++; $display("FAIL drop_no_out sel=%b got a=%b b=%b want 0 0", sels[i], out_a_valid, out_b_valid); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_err++; $display("FAIL drop_quiet got a=%b b=%b want 0 0", out_a_valid, out_b_valid); end
`ifdef SWITCH_DROP_CNT_EN
    n_cmp++; if (drop_cnt !== 4'd2) begin n_err++; $display("FAIL drop_cnt_two got %0d want 2", drop_cnt); end
    sel_a = 1'b1; sel_b = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (drop_cnt !== 4'hF) begin n_err++; $display("FAIL drop_cnt_full got %0d want 15", drop_cnt); end
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 4'hF) begin n_err++; $display("FAIL drop_cnt_sat got %0d want 15", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    sel_a = 1'b0; sel_b = 1'b0; in_data = 8'hA1; in_valid = 1'b1;
    tick();
    sel_a = 1'b1; sel_b = 1'b1; in_data = 8'hB2;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_a_valid !== 1'b1 || out_b_valid !== 1'b1) begin n_err++; $display("FAIL mid_both_full got a=%b b=%b want 1 1", out_a_valid, out_b_valid); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    n_cmp++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valids got a=%b b=%b want 0 0", out_a_valid, out_b_valid); end
    n_cmp++; if (out_a_data !== 8'h00 || out_b_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_data got %h/%h want 00/00", out_a_data, out_b_data); end
`ifdef SWITCH_DROP_CNT_EN
    n_cmp++; if (drop_cnt !== 4'd0) begin n_err++; $display("FAIL mid_rst_drop_cnt got %0d want 0", drop_cnt); end
`endif
    out_a_ready = 1'b1; out_b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_a_valid !== 1'b0 || out_b_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale cyc %0d got a=%b b=%b want 0 0", i, out_a_valid, out_b_valid); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; sel_a = 1'b0; sel_b = 1'b0; in_valid = 1'b0; in_data = '0;
    out_a_ready = 1'b0; out_b_ready = 1'b0;
    test_reset();
    test_single_a();
    test_back_to_back();
    test_stall_and_isolation();
    test_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_1to2.md
SWITCH_1TO2 -- requirements
Module: switch_1to2

Interface
REQ-001 Parameter DATA_W, default 8, width of the data path in bits.
REQ-002 Parameter CNT_W, default 16, width of the drop counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sel_a  input  1  destination select bit 0, sampled with in_valid.
REQ-006 sel_b  input  1  destination select bit 1, sampled with in_valid.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_data  input  DATA_W  input beat payload.
REQ-009 in_ready  output  1  block accepts the beat this cycle.
REQ-010 out_a_valid / out_a_data / out_a_ready  output / output / input  1 / DATA_W / 1  channel A stream.
REQ-011 out_b_valid / out_b_data / out_b_ready  output / output / input  1 / DATA_W / 1  channel B stream.
REQ-012 drop_cnt  output  CNT_W  dropped-beat count; present only when SWITCH_DROP_CNT_EN is defined.

Function
REQ-013 Decode is {sel_b,sel_a}: 00 selects DEST_A, 11 selects DEST_B, and 01 or 10 selects DEST_DROP.
REQ-014 Input transfer occurs on a cycle with in_valid and in_ready both high; sel and data are sampled only on transfer.
REQ-015 Each channel holds a one-entry output slot with two states: EMPTY (valid=0) and FULL (valid=1).
REQ-016 A slot goes EMPTY->FULL when it loads, FULL->EMPTY when consumed (valid&ready) with no load, and stays FULL with new data when consumed and loaded in the same cycle.
REQ-017 in_ready is combinational: DEST_A -> (~out_a_valid | out_a_ready); DEST_B -> (~out_b_valid | out_b_ready); DEST_DROP -> 1.
REQ-018 A transfer to DEST_A/DEST_B loads in_data into that slot; data appears on out_x_data with out_x_valid high the cycle after transfer (latency 1).
REQ-019 Sustained throughput is one beat per cycle per channel when the downstream ready is held high.
REQ-020 A DEST_DROP transfer is consumed in one cycle and produces no output beat on either channel.
REQ-021 While out_x_valid=1 and out_x_ready=0, out_x_data and out_x_valid are held stable.
REQ-022 A transfer never modifies the non-selected channel's slot; both channels drain independently and concurrently.
REQ-023 in_ready shall not depend on in_valid.

Reset
REQ-024 While rst=1 at a clock edge: out_a_valid=0, out_b_valid=0, out_a_data=0, out_b_data=0, drop_cnt=0.
REQ-025 Reset asserted mid-operation discards any held slot data, and no beat is emitted for it after reset.
REQ-026 in_ready is forced to 0 while rst=1.

Configuration
REQ-027 Macro SWITCH_DROP_CNT_EN defined: drop_cnt increments by 1 per DEST_DROP transfer and saturates at all-ones.
REQ-028 Macro SWITCH_DROP_CNT_EN undefined: no counter logic and no drop_cnt port; drops are silent and all other behaviour is identical.

Structure
REQ-029 Package switch_pkg holds the dest enum (DEST_A, DEST_B, DEST_DROP) and the decode function from {sel_b,sel_a}.
REQ-030 Sub-module out_slot (parameter DATA_W) implements one EMPTY/FULL slot and is instantiated twice; the top holds the decode, in_ready mux and drop counter.

Verification
REQ-031 Reset, then sel=00 with data 0x5A and out_a_ready=1 -> out_a_valid=1 with 0x5A one cycle later; out_b_valid stays 0.
REQ-032 sel=11, 4 back-to-back beats 0x01..0x04 with out_b_ready=1 -> B emits 0x01..0x04 on consecutive cycles and in_ready stays 1.
REQ-033 sel=00 with out_a_ready=0, send 0x11 then 0x22 -> A holds 0x11 and in_ready=0 for the second beat; raising out_a_ready gives 0x11 then 0x22.
REQ-034 A stalled holding 0x11 while sel=11 sends 0x33 -> B emits 0x33 unaffected; A still holds 0x11.
REQ-035 Drop case, counter enabled: sel=01 then sel=10, one beat each -> no output beats, in_ready=1, drop_cnt=2; preloading all-ones -> drop_cnt stays all-ones.
REQ-036 Both slots FULL and stalled, then assert rst for 1 cycle -> both valids 0 the next cycle and no stale beat is emitted afterwards.
